// File: rtl/uart_digit_rx.sv
// ---------------------------------------------------------------------------
// uart_digit_rx
//
// UART receiver for a Bluetooth serial link. It decodes 8-bit frames
// (LSB first, one stop bit) and classifies each good byte as either an ASCII
// decimal digit or a non-digit. For digits it also returns the binary value.
//
// Build option:
//   UART_PARITY_EN  when defined, each frame carries an even-parity bit
//                   between data bit 7 and the stop bit. A parity mismatch
//                   reports frame_err instead of a byte. When undefined the
//                   framing is 8N1 and no parity logic is built.
//
// Parameters:
//   CLK_FREQ     system clock in Hz
//   BAUD         serial bit rate; CLK_FREQ/BAUD must be at least 4
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   rx           serial input, idle high, asynchronous to clk
//   rx_byte      last good byte received (registered)
//   byte_valid   one-cycle pulse when rx_byte updates
//   digit        value of the last ASCII digit received, held
//   digit_valid  one-cycle pulse when digit updates
//   nondigit     one-cycle pulse when a good byte is not '0'..'9'
//   frame_err    one-cycle pulse on a bad stop bit (or a parity error)
//   busy         high while the receiver is inside a frame
// ---------------------------------------------------------------------------
module uart_digit_rx #(
    parameter int CLK_FREQ = 27000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       nondigit,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;

    // Mid-bit sample point of the start bit, and the full-bit sample point
    // used for every later bit.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchronizer. Both stages reset high so that reset release never
    // looks like a falling edge on an idle line.
    // -----------------------------------------------------------------------
    logic [1:0] rx_sync_reg;
    logic       rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync_reg <= 2'b11;
        end else begin
            rx_sync_reg <= {rx_sync_reg[0], rx};
        end
    end

    assign rx_s = rx_sync_reg[1];

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t           state_reg,       state_next;
    logic [CNT_W-1:0] cnt_reg,         cnt_next;
    logic [2:0]       bit_idx_reg,     bit_idx_next;
    logic [7:0]       shift_reg,       shift_next;
    logic [7:0]       rx_byte_reg,     rx_byte_next;
    logic [3:0]       digit_reg,       digit_next;
    logic             byte_valid_reg,  byte_valid_next;
    logic             digit_valid_reg, digit_valid_next;
    logic             nondigit_reg,    nondigit_next;
    logic             frame_err_reg,   frame_err_next;
    // Set after a framing error: the line must be seen high before a new
    // start bit is accepted, so a held-low break does not retrigger.
    logic             rearm_wait_reg,  rearm_wait_next;
`ifdef UART_PARITY_EN
    logic             parity_err_reg,  parity_err_next;
`endif

    logic             stop_ok;
    logic             is_digit;

    assign is_digit = (shift_reg >= 8'h30) && (shift_reg <= 8'h39);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            bit_idx_reg     <= '0;
            shift_reg       <= '0;
            rx_byte_reg     <= '0;
            digit_reg       <= '0;
            byte_valid_reg  <= 1'b0;
            digit_valid_reg <= 1'b0;
            nondigit_reg    <= 1'b0;
            frame_err_reg   <= 1'b0;
            rearm_wait_reg  <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err_reg  <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            bit_idx_reg     <= bit_idx_next;
            shift_reg       <= shift_next;
            rx_byte_reg     <= rx_byte_next;
            digit_reg       <= digit_next;
            byte_valid_reg  <= byte_valid_next;
            digit_valid_reg <= digit_valid_next;
            nondigit_reg    <= nondigit_next;
            frame_err_reg   <= frame_err_next;
            rearm_wait_reg  <= rearm_wait_next;
`ifdef UART_PARITY_EN
            parity_err_reg  <= parity_err_next;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg + 1'b1;
        bit_idx_next     = bit_idx_reg;
        shift_next       = shift_reg;
        rx_byte_next     = rx_byte_reg;
        digit_next       = digit_reg;
        byte_valid_next  = 1'b0;
        digit_valid_next = 1'b0;
        nondigit_next    = 1'b0;
        frame_err_next   = 1'b0;
        rearm_wait_next  = rearm_wait_reg;
`ifdef UART_PARITY_EN
        parity_err_next  = parity_err_reg;
        stop_ok          = rx_s && !parity_err_reg;
`else
        stop_ok          = rx_s;
`endif

        case (state_reg)
            IDLE: begin
                cnt_next     = '0;
                bit_idx_next = '0;
`ifdef UART_PARITY_EN
                parity_err_next = 1'b0;
`endif
                if (rearm_wait_reg) begin
                    if (rx_s) begin
                        rearm_wait_next = 1'b0;
                    end
                end else if (!rx_s) begin
                    state_next = START;
                end
            end

            START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next = '0;
                    // Line back high at mid start bit: a glitch, not a frame.
                    state_next = rx_s ? IDLE : DATA;
                end
            end

            DATA: begin
                if (cnt_reg == FULL_LAST) begin
                    cnt_next     = '0;
                    shift_next   = {rx_s, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 1'b1;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end

`ifdef UART_PARITY_EN
            PARITY: begin
                if (cnt_reg == FULL_LAST) begin
                    cnt_next        = '0;
                    // Even parity: data bits plus parity bit XOR to zero.
                    parity_err_next = rx_s ^ (^shift_reg);
                    state_next      = STOP;
                end
            end
`endif

            STOP: begin
                if (cnt_reg == FULL_LAST) begin
                    // Leave on the stop sample rather than waiting out the
                    // stop bit, so a frame that follows immediately is seen.
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (stop_ok) begin
                        rx_byte_next    = shift_reg;
                        byte_valid_next = 1'b1;
                        if (is_digit) begin
                            // '0' is 0x30, whose low nibble is zero, so the
                            // low nibble is already byte - 0x30.
                            digit_next       = shift_reg[3:0];
                            digit_valid_next = 1'b1;
                        end else begin
                            nondigit_next = 1'b1;
                        end
                    end else begin
                        frame_err_next  = 1'b1;
                        rearm_wait_next = 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign rx_byte     = rx_byte_reg;
    assign byte_valid  = byte_valid_reg;
    assign digit       = digit_reg;
    assign digit_valid = digit_valid_reg;
    assign nondigit    = nondigit_reg;
    assign frame_err   = frame_err_reg;
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_digit_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_digit_rx
//
// Scoreboard bench for uart_digit_rx with CLK_FREQ=160, BAUD=10 (16 clocks
// per bit). The stimulus pushes the expected result of each frame into a
// queue; a monitor pops and compares whenever the receiver pulses an output.
// Expected results are hand-written constants.
// Define UART_PARITY_EN for both bench and design to cover the parity build.
// ---------------------------------------------------------------------------
module tb_uart_digit_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_byte;
    logic       byte_valid;
    logic [3:0] digit;
    logic       digit_valid;
    logic       nondigit;
    logic       frame_err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // {byte_valid, digit_valid, nondigit, frame_err, rx_byte, digit}
    typedef struct packed {
        logic       bv;
        logic       dv;
        logic       nd;
        logic       fe;
        logic [7:0] b;
        logic [3:0] d;
    } exp_t;

    exp_t exp_q[$];

    uart_digit_rx #(
        .CLK_FREQ(160),
        .BAUD    (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .digit      (digit),
        .digit_valid(digit_valid),
        .nondigit   (nondigit),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic expect_frame(input logic bv, input logic dv, input logic nd, input logic fe,
                                input logic [7:0] b, input logic [3:0] d);
        exp_t e;
        e = {bv, dv, nd, fe, b, d};
        exp_q.push_back(e);
    endtask

    // Inputs change on the falling edge, away from the sampling edge.
    task automatic send_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_PARITY_EN
        send_bit(^b);
`endif
        send_bit(stop_v);
    endtask

`ifdef UART_PARITY_EN
    task automatic send_frame_par(input logic [7:0] b, input logic par_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par_v);
        send_bit(1'b1);
    endtask
`endif

    // Monitor: every pulse must match the next queued expectation.
    always @(negedge clk) begin
        exp_t act;
        exp_t e;
        if (!rst && (byte_valid || digit_valid || nondigit || frame_err)) begin
            act = {byte_valid, digit_valid, nondigit, frame_err, rx_byte, digit};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got %04h, required no pulse", act);
            end else begin
                e = exp_q.pop_front();
                check("frame_result", 32'(act), 32'(e));
            end
        end
    end

    initial begin
        logic saw_busy;

        // Reset state
        repeat (4) @(negedge clk);
        check("reset_rx_byte", 32'(rx_byte), 32'h00);
        check("reset_digit",   32'(digit),   32'h0);
        check("reset_pulses",  32'({byte_valid, digit_valid, nondigit, frame_err}), 32'h0);
        check("reset_busy",    32'(busy),    32'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // '7'
        expect_frame(1, 1, 0, 0, 8'h37, 4'd7);
        send_frame(8'h37, 1'b1);
        // '5' then 'A': digit holds 5
        expect_frame(1, 1, 0, 0, 8'h35, 4'd5);
        send_frame(8'h35, 1'b1);
        expect_frame(1, 0, 1, 0, 8'h41, 4'd5);
        send_frame(8'h41, 1'b1);
        // '2' with a low stop bit: frame error, byte and digit unchanged
        expect_frame(0, 0, 0, 1, 8'h41, 4'd5);
        send_frame(8'h32, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        // '9' after the error
        expect_frame(1, 1, 0, 0, 8'h39, 4'd9);
        send_frame(8'h39, 1'b1);
        repeat (20) @(negedge clk);

        // 4-cycle low glitch
        saw_busy = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 28; i++) begin
            if (i == 4) rx = 1'b1;
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        check("glitch_busy_rose", 32'(saw_busy), 32'h1);
        check("glitch_busy_fell", 32'(busy),     32'h0);

        // Back-to-back '1','2','3'
        expect_frame(1, 1, 0, 0, 8'h31, 4'd1);
        expect_frame(1, 1, 0, 0, 8'h32, 4'd2);
        expect_frame(1, 1, 0, 0, 8'h33, 4'd3);
        send_frame(8'h31, 1'b1);
        send_frame(8'h32, 1'b1);
        send_frame(8'h33, 1'b1);
        repeat (20) @(negedge clk);

        // Reset in the middle of bit 4 of '8' (0x38): no pulse expected
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_busy",    32'(busy),    32'h0);
        check("midreset_rx_byte", 32'(rx_byte), 32'h00);
        check("midreset_digit",   32'(digit),   32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (32) @(negedge clk);
        check("after_reset_busy", 32'(busy), 32'h0);

        // '4' as a fresh frame
`ifdef UART_PARITY_EN
        expect_frame(0, 0, 0, 1, 8'h00, 4'd0);
        send_frame_par(8'h34, 1'b0);
`else
        expect_frame(1, 1, 0, 0, 8'h34, 4'd4);
        send_frame(8'h34, 1'b1);
`endif
        repeat (40) @(negedge clk);

        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
